mem_if_mc: RTL and testbench
============================

# mem_if_mc

Memory interface for the multi-cycle RV32I core, directly downstream of the multi-cycle controller. It takes the controller's `mem_r`, `mem_w` and `i_d_mem` strobes, runs one transaction at a time over a single-ported req/ack bus, and writes the result into the instruction register (`ir`) or the memory data register (`mdr`). It also handles load/store sizing (byte enables, lane placement, sign extension), detects misalignment, and drives `busy` so the controller can stall.

## Interface
- `RESET_IR`, default 32'h00000013 (NOP): value loaded into `ir` on reset.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high; clock `clk`.
- `mem_r` in 1: read request strobe from the controller.
- `mem_w` in 1: write request strobe from the controller.
- `i_d_mem` in 1: address select. 0 = instruction fetch at `pc`; 1 = data access at `alu_addr`.
- `pc` in 32: fetch address.
- `alu_addr` in 32: data address.
- `funct3` in 3: access size/sign. 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `store_data` in 32: rs2 value for stores.
- `ir` out 32: instruction register.
- `mdr` out 32: load data register, already sign/zero-extended.
- `busy` out 1: a transaction is in flight.
- `done` out 1: one-cycle pulse when a transaction completes.
- `err` out 1: one-cycle pulse on a misaligned or illegal request.
- `bus_req` out 1: bus request, held high until ack.
- `bus_we` out 1: write enable.
- `bus_addr` out 32: word-aligned address (bits [1:0] = 00).
- `bus_be` out 4: byte enables.
- `bus_wdata` out 32: write data.
- `bus_rdata` in 32: read data, valid when `bus_ack` is high.
- `bus_ack` in 1: transaction complete.

## Operation
- FSM states: IDLE, WAIT_ACK, DONE.
- **Accept (IDLE only):** on an edge where `mem_r` or `mem_w` is high, latch address, `i_d_mem`, `funct3`, direction and `store_data`.
  - Instruction fetch (`i_d_mem`=0) ignores `funct3` and is always a 32-bit read.
- **Error checks (at accept):** the request is rejected if any of these hold:
  - half-word access with addr[0]=1;
  - word access or fetch with addr[1:0]≠00;
  - `mem_r` and `mem_w` both high;
  - `mem_w` with `i_d_mem`=0;
  - `funct3` equal to 011, 110 or 111.
- **On rejection:** `err` pulses for one cycle, the FSM stays in IDLE, no bus activity occurs, and `ir`/`mdr` keep their values.
- **Valid request:** move to WAIT_ACK. Outputs driven while in WAIT_ACK:
  - `bus_req`=1, `busy`=1;
  - `bus_addr` = {addr[31:2], 2'b00};
  - `bus_we` = 1 for writes, 0 for reads.
- **Writes:**
  - SB: `bus_be` = 4'b0001 << addr[1:0]; `bus_wdata` = the low byte of `store_data` replicated to all four lanes.
  - SH: `bus_be` = addr[1] ? 1100 : 0011; `bus_wdata` = the low halfword replicated to both halves.
  - SW: `bus_be` = 1111; `bus_wdata` = `store_data`.
- **Reads:** `bus_be` = 1111.
- **Ack:** on an edge in WAIT_ACK with `bus_ack`=1:
  - a fetch loads `bus_rdata` into `ir`;
  - a data read loads the selected lane (byte at addr[1:0], halfword at addr[1]) into `mdr`, sign-extended for B/H and zero-extended for BU/HU;
  - a write updates no register;
  - the FSM moves to DONE.
- **DONE:** lasts one cycle with `done`=1, `busy`=0, `bus_req`=0, then returns to IDLE. New requests are not accepted in DONE.
- **Ignored inputs:**
  - `mem_r`/`mem_w` while in WAIT_ACK or DONE (the controller must hold off while `busy` is high).
  - `bus_ack` in IDLE or DONE.
- **Reset:** applies in any state, including mid-transaction. After the reset edge: state IDLE, `ir`=`RESET_IR`, `mdr`=0, `busy`=`done`=`err`=0, `bus_req`=`bus_we`=0, `bus_addr`=0, `bus_be`=0, `bus_wdata`=0. A late `bus_ack` arriving after reset is ignored.

## Timing
- All outputs are registered.
- Request sampled at edge t0 → `bus_req` and `busy` high from t0 until the ack edge.
- `bus_ack` sampled at edge t1 ≥ t0+1 → `ir`/`mdr` valid and `done`=1 after t1. `bus_req` and `busy` drop after t1.
- Minimum latency is 2 edges from request to updated register. The next request can be accepted at t1+2.
- `bus_addr`, `bus_be`, `bus_we` and `bus_wdata` are stable for the entire time `bus_req` is high.
- `err` is high for the cycle after the rejecting edge.

## Test plan
- **Fetch:** `pc`=0x100, `mem_r`=1, `i_d_mem`=0; ack 3 cycles later with `bus_rdata`=0x00A00093. Required: `bus_addr`=0x100, `bus_be`=1111, `busy` high for 3 cycles, then `ir`=0x00A00093 and a 1-cycle `done` pulse.
- **Signed/unsigned byte loads:** `bus_rdata`=0x80FF7F01.
  - LB at `alu_addr`=0x203 → `mdr`=0xFFFFFF80.
  - LBU at 0x202 → `mdr`=0x000000FF.
  - LH at 0x200 → `mdr`=0x00007F01.
- **Stores:**
  - SB at 0x301 with `store_data`=0x12345678 → `bus_be`=0010, `bus_wdata`=0x78787878, `bus_we`=1.
  - SH at 0x302 → `bus_be`=1100, `bus_wdata`=0x56785678.
- **Misalignment:** LW at 0x402 and SH at 0x401 → `err` pulses, `bus_req` never rises, `mdr` unchanged. `mem_r`=`mem_w`=1 → `err`.
- **Reset mid-transaction:** assert `rst` during WAIT_ACK → after the reset edge, `bus_req`=0, `busy`=0, `ir`=0x00000013. A subsequent `bus_ack` leaves `ir`/`mdr` unchanged.
- **Back-to-back:** a new `mem_r` held high during WAIT_ACK and DONE is not accepted until IDLE. Ack in the same cycle `bus_req` first rises → `done` on the next cycle.

Source files
------------

// File: rtl/mem_if_mc.sv
// mem_if_mc
// Memory interface between the multi-cycle RV32I controller and a single-ported
// req/ack bus. It runs one transaction at a time. It places store data on the
// correct byte lanes and extracts and extends load data. The fetched word goes
// into ir and the extended load goes into mdr.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   mem_r, mem_w    : read / write strobes from the controller
//   i_d_mem         : 0 = fetch at pc, 1 = data access at alu_addr
//   pc, alu_addr    : fetch address / data address
//   funct3          : access size and sign (B, H, W, BU, HU)
//   store_data      : rs2 value for stores
//   ir, mdr         : instruction register / extended load data
//   busy, done, err : in-flight flag, completion pulse, rejection pulse
//   bus_*           : req/ack bus, word-aligned address, byte enables

module mem_if_mc #(
    parameter logic [31:0] RESET_IR = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_r,
    input  logic        mem_w,
    input  logic        i_d_mem,
    input  logic [31:0] pc,
    input  logic [31:0] alu_addr,
    input  logic [2:0]  funct3,
    input  logic [31:0] store_data,
    output logic [31:0] ir,
    output logic [31:0] mdr,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        DONE     = 2'd2
    } state_t;

    state_t      state;

    logic        lat_fetch;
    logic        lat_write;
    logic [2:0]  lat_f3;
    logic [1:0]  lat_off;

    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_bad;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    // Decode the incoming request.
    // A fetch is always treated as a word read, whatever funct3 carries.
    // Size code 00 = byte, 01 = half, 10 = word. It comes from funct3[1:0].
    // The unsigned variants therefore share a size with their signed versions.
    always_comb begin
        req_addr  = i_d_mem ? alu_addr : pc;
        req_size  = i_d_mem ? funct3[1:0] : 2'b10;
        req_bad   = 1'b0;
        req_be    = 4'b1111;
        req_wdata = store_data;

        if (mem_r && mem_w)
            req_bad = 1'b1;
        if (mem_w && !i_d_mem)
            req_bad = 1'b1;
        if (i_d_mem && (funct3 == 3'b011 || funct3[2:1] == 2'b11))
            req_bad = 1'b1;
        if (req_size == 2'b01 && req_addr[0])
            req_bad = 1'b1;
        if (req_size == 2'b10 && req_addr[1:0] != 2'b00)
            req_bad = 1'b1;

        // Store data is replicated across lanes, so the bus_be mask selects the lane.
        if (mem_w) begin
            case (req_size)
                2'b00: begin
                    req_be    = 4'b0001 << req_addr[1:0];
                    req_wdata = {4{store_data[7:0]}};
                end
                2'b01: begin
                    req_be    = req_addr[1] ? 4'b1100 : 4'b0011;
                    req_wdata = {2{store_data[15:0]}};
                end
                default: begin
                    req_be    = 4'b1111;
                    req_wdata = store_data;
                end
            endcase
        end
    end

    // Select the load lane from the latched address offset.
    // Then extend it according to the latched funct3.
    always_comb begin
        case (lat_off)
            2'd0:    ld_byte = bus_rdata[7:0];
            2'd1:    ld_byte = bus_rdata[15:8];
            2'd2:    ld_byte = bus_rdata[23:16];
            default: ld_byte = bus_rdata[31:24];
        endcase
        ld_half = lat_off[1] ? bus_rdata[31:16] : bus_rdata[15:0];

        case (lat_f3)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {24'd0, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_data = {16'd0, ld_half};
            default: ld_data = bus_rdata;
        endcase
    end

    // Transaction FSM. Every output is a register.
    // In IDLE the FSM either accepts a request or rejects it with an err pulse.
    // In WAIT_ACK it holds the bus fields steady until the ack arrives.
    // DONE lasts one cycle, so the controller sees done and busy=0 before
    // the next request can be accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ir        <= RESET_IR;
            mdr       <= 32'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'd0;
            bus_be    <= 4'd0;
            bus_wdata <= 32'd0;
            lat_fetch <= 1'b0;
            lat_write <= 1'b0;
            lat_f3    <= 3'd0;
            lat_off   <= 2'd0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_r || mem_w) begin
                        if (req_bad) begin
                            err <= 1'b1;
                        end else begin
                            lat_fetch <= !i_d_mem;
                            lat_write <= mem_w;
                            lat_f3    <= i_d_mem ? funct3 : 3'b010;
                            lat_off   <= req_addr[1:0];
                            bus_req   <= 1'b1;
                            busy      <= 1'b1;
                            bus_we    <= mem_w;
                            bus_addr  <= {req_addr[31:2], 2'b00};
                            bus_be    <= req_be;
                            bus_wdata <= req_wdata;
                            state     <= WAIT_ACK;
                        end
                    end
                end
                WAIT_ACK: begin
                    if (bus_ack) begin
                        if (!lat_write) begin
                            if (lat_fetch)
                                ir <= bus_rdata;
                            else
                                mdr <= ld_data;
                        end
                        bus_req <= 1'b0;
                        busy    <= 1'b0;
                        bus_we  <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_if_mc.sv
// tb_mem_if_mc
// Directed testbench for mem_if_mc. The stimulus tasks push the expected
// response of each request into a scoreboard queue. A separate monitor pops
// one entry whenever the DUT raises done or err and compares it. Bus-side
// fields are checked directly while the transaction is in flight.

module tb_mem_if_mc;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_r, mem_w, i_d_mem;
    logic [31:0] pc, alu_addr;
    logic [2:0]  funct3;
    logic [31:0] store_data;
    logic [31:0] ir, mdr;
    logic        busy, done, err;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    localparam int KIR  = 0;
    localparam int KMDR = 1;
    localparam int KWR  = 2;
    localparam int KERR = 3;

    typedef struct {
        int          kind;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t        sbq[$];
    exp_t        monE;
    int          testsRun = 0;
    int          testsFailed = 0;
    logic [31:0] expMdr = 32'd0;

    mem_if_mc #(.RESET_IR(32'h00000013)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_r      (mem_r),
        .mem_w      (mem_w),
        .i_d_mem    (i_d_mem),
        .pc         (pc),
        .alu_addr   (alu_addr),
        .funct3     (funct3),
        .store_data (store_data),
        .ir         (ir),
        .mdr        (mdr),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_be     (bus_be),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .bus_ack    (bus_ack)
    );

    // Free-running clock with a 10 ns period.
    always #5 clk = ~clk;

    // Scoreboard monitor. It samples on the falling edge, away from the
    // edge where the DUT updates. Each done or err pulse consumes exactly
    // one expectation from the queue.
    always @(negedge clk) begin
        if (!rst && (done || err)) begin
            testsRun++;
            if (sbq.size() == 0) begin
                testsFailed++;
                $display("[TB] FAIL unexpected_resp: done=%0b err=%0b with empty scoreboard", done, err);
            end else begin
                monE = sbq.pop_front();
                if (monE.kind == KERR) begin
                    if (!(err && !done)) begin
                        testsFailed++;
                        $display("[TB] FAIL %s: got done=%0b err=%0b, want err only", monE.name, done, err);
                    end
                end else if (!(done && !err)) begin
                    testsFailed++;
                    $display("[TB] FAIL %s: got done=%0b err=%0b, want done only", monE.name, done, err);
                end else if (monE.kind == KIR && ir !== monE.val) begin
                    testsFailed++;
                    $display("[TB] FAIL %s: ir got %h want %h", monE.name, ir, monE.val);
                end else if ((monE.kind == KMDR || monE.kind == KWR) && mdr !== monE.val) begin
                    testsFailed++;
                    $display("[TB] FAIL %s: mdr got %h want %h", monE.name, mdr, monE.val);
                end
            end
        end
    end

    // Compare one observed value against its expected value and count the result.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h want %h", name, actual, expected);
        end
    endtask

    // Drive a one-cycle request, starting from a falling edge.
    // The unused address input is driven with junk, so a wrong address mux
    // shows up in the results. The task returns on the falling edge after
    // the edge that sampled the request.
    task automatic applyStimulus(input logic r, input logic w, input logic idm,
                                 input logic [31:0] addr, input logic [2:0] f3,
                                 input logic [31:0] sd);
        mem_r      = r;
        mem_w      = w;
        i_d_mem    = idm;
        pc         = idm ? 32'hFFFF_FFF0 : addr;
        alu_addr   = idm ? addr : 32'hFFFF_FFF0;
        funct3     = f3;
        store_data = sd;
        @(negedge clk);
        mem_r = 1'b0;
        mem_w = 1'b0;
    endtask

    // Keep busy high for waitCycles falling edges, then ack for one cycle.
    // The task returns on the falling edge of the DONE cycle.
    task automatic ackBus(input int waitCycles, input logic [31:0] rdata);
        for (int i = 0; i < waitCycles; i++) begin
            checkOutput("busy_wait", {31'd0, busy}, 32'd1);
            if (i != waitCycles - 1) @(negedge clk);
        end
        bus_rdata = rdata;
        bus_ack   = 1'b1;
        @(negedge clk);
        bus_ack   = 1'b0;
    endtask

    task automatic doLoad(input string name, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] expAddr, input logic [31:0] rdata,
                          input logic [31:0] expVal);
        sbq.push_back('{KMDR, expVal, name});
        expMdr = expVal;
        applyStimulus(1'b1, 1'b0, 1'b1, addr, f3, 32'h0);
        checkOutput({name, "_addr"}, bus_addr, expAddr);
        checkOutput({name, "_be"}, {28'd0, bus_be}, 32'h0000000F);
        checkOutput({name, "_we"}, {31'd0, bus_we}, 32'd0);
        ackBus(1, rdata);
        @(negedge clk);
    endtask

    task automatic doStore(input string name, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] sd, input logic [31:0] expAddr,
                           input logic [3:0] expBe, input logic [31:0] expWdata);
        sbq.push_back('{KWR, expMdr, name});
        applyStimulus(1'b0, 1'b1, 1'b1, addr, f3, sd);
        checkOutput({name, "_addr"}, bus_addr, expAddr);
        checkOutput({name, "_be"}, {28'd0, bus_be}, {28'd0, expBe});
        checkOutput({name, "_wdata"}, bus_wdata, expWdata);
        checkOutput({name, "_we"}, {31'd0, bus_we}, 32'd1);
        @(negedge clk);
        checkOutput({name, "_wdata_hold"}, bus_wdata, expWdata);
        ackBus(1, 32'hDEADBEEF);
        @(negedge clk);
    endtask

    task automatic doReject(input string name, input logic r, input logic w, input logic idm,
                            input logic [31:0] addr, input logic [2:0] f3);
        sbq.push_back('{KERR, 32'd0, name});
        applyStimulus(r, w, idm, addr, f3, 32'hCAFEF00D);
        checkOutput({name, "_noreq"}, {31'd0, bus_req}, 32'd0);
        checkOutput({name, "_mdr"}, mdr, expMdr);
        @(negedge clk);
        checkOutput({name, "_errpulse"}, {31'd0, err}, 32'd0);
        checkOutput({name, "_noreq2"}, {31'd0, bus_req}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; mem_r = 1'b0; mem_w = 1'b0; i_d_mem = 1'b0;
        pc = 32'd0; alu_addr = 32'd0; funct3 = 3'd0; store_data = 32'd0;
        bus_rdata = 32'd0; bus_ack = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        checkOutput("rst_ir", ir, 32'h00000013);
        checkOutput("rst_mdr", mdr, 32'd0);
        checkOutput("rst_flags", {27'd0, busy, done, err, bus_req, bus_we}, 32'd0);
        checkOutput("rst_addr", bus_addr, 32'd0);
        checkOutput("rst_be", {28'd0, bus_be}, 32'd0);

        // Instruction fetch that waits three cycles for the ack
        sbq.push_back('{KIR, 32'h00A00093, "fetch"});
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h00000100, 3'b000, 32'h0);
        checkOutput("fetch_addr", bus_addr, 32'h00000100);
        checkOutput("fetch_be", {28'd0, bus_be}, 32'h0000000F);
        checkOutput("fetch_req", {31'd0, bus_req}, 32'd1);
        ackBus(3, 32'h00A00093);
        checkOutput("fetch_notbusy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        checkOutput("fetch_done_pulse", {31'd0, done}, 32'd0);

        // Loads of every size and sign
        doLoad("lb_203", 3'b000, 32'h00000203, 32'h00000200, 32'h80FF7F01, 32'hFFFFFF80);
        doLoad("lbu_202", 3'b100, 32'h00000202, 32'h00000200, 32'h80FF7F01, 32'h000000FF);
        doLoad("lh_200", 3'b001, 32'h00000200, 32'h00000200, 32'h80FF7F01, 32'h00007F01);
        doLoad("lh_202", 3'b001, 32'h00000202, 32'h00000200, 32'h80FF7F01, 32'hFFFF80FF);
        doLoad("lhu_202", 3'b101, 32'h00000202, 32'h00000200, 32'h80FF7F01, 32'h000080FF);
        doLoad("lw_204", 3'b010, 32'h00000204, 32'h00000204, 32'h80FF7F01, 32'h80FF7F01);
        checkOutput("ir_after_loads", ir, 32'h00A00093);

        // Stores
        doStore("sb_301", 3'b000, 32'h00000301, 32'h12345678, 32'h00000300, 4'b0010, 32'h78787878);
        doStore("sh_302", 3'b001, 32'h00000302, 32'h12345678, 32'h00000300, 4'b1100, 32'h56785678);
        doStore("sw_304", 3'b010, 32'h00000304, 32'h12345678, 32'h00000304, 4'b1111, 32'h12345678);

        // Rejected requests
        doReject("lw_402", 1'b1, 1'b0, 1'b1, 32'h00000402, 3'b010);
        doReject("sh_401", 1'b0, 1'b1, 1'b1, 32'h00000401, 3'b001);
        doReject("r_and_w", 1'b1, 1'b1, 1'b1, 32'h00000400, 3'b010);
        doReject("f3_011", 1'b1, 1'b0, 1'b1, 32'h00000400, 3'b011);
        doReject("store_fetch", 1'b0, 1'b1, 1'b0, 32'h00000400, 3'b010);
        doReject("fetch_mis", 1'b1, 1'b0, 1'b0, 32'h00000102, 3'b000);

        // Reset while waiting for the ack; the late ack must be ignored
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h00000104, 3'b000, 32'h0);
        checkOutput("mid_req", {31'd0, bus_req}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        expMdr = 32'd0;
        checkOutput("mid_rst_req", {31'd0, bus_req}, 32'd0);
        checkOutput("mid_rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("mid_rst_ir", ir, 32'h00000013);
        bus_rdata = 32'hFFFFFFFF;
        bus_ack   = 1'b1;
        @(negedge clk);
        bus_ack   = 1'b0;
        checkOutput("late_ack_ir", ir, 32'h00000013);
        checkOutput("late_ack_mdr", mdr, 32'd0);
        checkOutput("late_ack_done", {31'd0, done}, 32'd0);
        @(negedge clk);

        // Back-to-back: mem_r is held high, and the first ack arrives with the first bus_req
        sbq.push_back('{KMDR, 32'h11112222, "b2b_first"});
        sbq.push_back('{KMDR, 32'h33334444, "b2b_second"});
        mem_r = 1'b1; mem_w = 1'b0; i_d_mem = 1'b1; alu_addr = 32'h00000500;
        funct3 = 3'b010; pc = 32'hFFFF_FFF0;
        @(negedge clk);
        checkOutput("b2b_req", {31'd0, bus_req}, 32'd1);
        bus_rdata = 32'h11112222;
        bus_ack   = 1'b1;
        @(negedge clk);
        bus_ack   = 1'b0;
        checkOutput("b2b_done_next", {31'd0, done}, 32'd1);
        checkOutput("b2b_busy_done", {31'd0, busy}, 32'd0);
        @(negedge clk);
        checkOutput("b2b_noaccept_done", {31'd0, bus_req}, 32'd0);
        @(negedge clk);
        mem_r = 1'b0;
        checkOutput("b2b_accept_idle", {31'd0, bus_req}, 32'd1);
        ackBus(1, 32'h33334444);
        @(negedge clk);

        repeat (3) @(negedge clk);
        checkOutput("sb_drained", sbq.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
